axil_ctrl_regs: RTL and testbench

AXI4-Lite control-register responder for hand-written RTL kernels. It sits on the `s_axi_control_*` bus, as the target of the `host` bridge that translates `host_req_*` into AXI-Lite transactions. It provides the kernel with a start/done/idle/ready control word, two argument registers and a captured result register. The register map matches the HLS control layout, so host-side drivers are unchanged whether the kernel is an HLS kernel or RTL.

---
 rtl/axil_ctrl_pkg.sv | 30 +++
 rtl/axil_ctrl_if.sv | 42 ++++
 rtl/axil_ctrl_regs.sv | 155 +++++++++++++++
 tb/tb_axil_ctrl_regs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ctrl_pkg.sv
// Shared constants for the AXI-Lite kernel control block:
// register offsets, CTRL bit positions and the byte-strobe merge.
package axil_ctrl_pkg;

  localparam int CTRL_OFF   = 'h00;
  localparam int ARG_A_OFF  = 'h10;
  localparam int ARG_B_OFF  = 'h18;
  localparam int RESULT_OFF = 'h20;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;
  localparam int CTRL_READY = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [31:0] strb_merge(
    logic [31:0] old,
    logic [31:0] wd,
    logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_ctrl_if.sv
// AXI4-Lite bus bundle between the host bridge (master)
// and the kernel control registers (slave).
interface axil_ctrl_if #(
  parameter int HOST_AXI_ADDR_BITS = 6,
  parameter int HOST_AXI_DATA_BITS = 32
);
  localparam int A = HOST_AXI_ADDR_BITS;
  localparam int D = HOST_AXI_DATA_BITS;

  logic           AWVALID;
  logic           AWREADY;
  logic [A-1:0]   AWADDR;
  logic           WVALID;
  logic           WREADY;
  logic [D-1:0]   WDATA;
  logic [D/8-1:0] WSTRB;
  logic           BVALID;
  logic           BREADY;
  logic [1:0]     BRESP;
  logic           ARVALID;
  logic           ARREADY;
  logic [A-1:0]   ARADDR;
  logic           RVALID;
  logic           RREADY;
  logic [D-1:0]   RDATA;
  logic [1:0]     RRESP;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB,
    output BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB,
    input  BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP,
    output ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axil_ctrl_regs.sv
// AXI-Lite control registers for RTL kernels using the
// HLS control layout: CTRL, two args and a result.
module axil_ctrl_regs
  import axil_ctrl_pkg::*;
#(
  parameter int HOST_AXI_ADDR_BITS = 6,
  parameter int HOST_AXI_DATA_BITS = 32
) (
  input  logic        clock,
  input  logic        reset,
  axil_ctrl_if.slave  s_axi_control,
  output logic        ap_start,
  input  logic        ap_done,
  input  logic        ap_idle,
  input  logic        ap_ready,
  output logic [31:0] arg_a,
  output logic [31:0] arg_b,
  input  logic [31:0] result,
  input  logic        result_vld
);

  localparam int A = HOST_AXI_ADDR_BITS;
  localparam int D = HOST_AXI_DATA_BITS;
  localparam int W = A - 2;

  function automatic logic sel(
    logic [W-1:0] wa,
    int off
  );
    return wa == W'(off >> 2);
  endfunction

  logic         aw_full_q, aw_full_d;
  logic [W-1:0] aw_addr_q, aw_addr_d;
  logic         w_full_q, w_full_d;
  logic [D-1:0] w_data_q, w_data_d;
  logic [3:0]   w_strb_q, w_strb_d;
  logic         b_vld_q, b_vld_d;
  logic         r_vld_q, r_vld_d;
  logic [D-1:0] r_data_q, r_data_d;
  logic         start_q, start_d;
  logic         done_q, done_d;
  logic         ready_q, ready_d;
  logic [D-1:0] arg_a_q, arg_a_d;
  logic [D-1:0] arg_b_q, arg_b_d;
  logic [D-1:0] result_q, result_d;

  logic         aw_hs, w_hs, ar_hs, commit;
  logic [W-1:0] wa, ra;
  logic [D-1:0] wd, ctrl_rd, rd_map;
  logic [3:0]   ws;
  logic         rd_ctrl, set_start;
  logic         unused_addr_lsb;

  assign unused_addr_lsb = ^{s_axi_control.AWADDR[1:0],
                             s_axi_control.ARADDR[1:0]};

  always_comb begin
    aw_hs = s_axi_control.AWVALID & ~aw_full_q;
    w_hs  = s_axi_control.WVALID & ~w_full_q;
    ar_hs = s_axi_control.ARVALID & ~r_vld_q;
    // A beat arriving this edge counts as held, so the
    // commit can happen on its own handshake edge.
    wa = aw_full_q ? aw_addr_q : s_axi_control.AWADDR[A-1:2];
    wd = w_full_q ? w_data_q : s_axi_control.WDATA;
    ws = w_full_q ? w_strb_q : s_axi_control.WSTRB;
    commit = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~b_vld_q;
    ra = s_axi_control.ARADDR[A-1:2];

    ctrl_rd = '0;
    ctrl_rd[CTRL_START] = start_q;
    ctrl_rd[CTRL_DONE]  = done_q;
    ctrl_rd[CTRL_IDLE]  = ap_idle;
    ctrl_rd[CTRL_READY] = ready_q;

    unique case (1'b1)
      sel(ra, CTRL_OFF):   rd_map = ctrl_rd;
      sel(ra, ARG_A_OFF):  rd_map = arg_a_q;
      sel(ra, ARG_B_OFF):  rd_map = arg_b_q;
      sel(ra, RESULT_OFF): rd_map = result_q;
      default:             rd_map = '0;
    endcase

    aw_full_d = (aw_full_q | aw_hs) & ~commit;
    aw_addr_d = aw_hs ? s_axi_control.AWADDR[A-1:2] : aw_addr_q;
    w_full_d  = (w_full_q | w_hs) & ~commit;
    w_data_d  = w_hs ? s_axi_control.WDATA : w_data_q;
    w_strb_d  = w_hs ? s_axi_control.WSTRB : w_strb_q;
    b_vld_d   = commit | (b_vld_q & ~s_axi_control.BREADY);

    r_vld_d  = ar_hs | (r_vld_q & ~s_axi_control.RREADY);
    r_data_d = ar_hs ? rd_map : r_data_q;

    set_start = commit & sel(wa, CTRL_OFF) & ws[0] & wd[0];
    start_d   = set_start | (start_q & ~ap_ready);
    // A pulse on the read edge survives the clear.
    rd_ctrl = ar_hs & sel(ra, CTRL_OFF);
    done_d  = ap_done | (done_q & ~rd_ctrl);
    ready_d = ap_ready | (ready_q & ~rd_ctrl);

    arg_a_d = arg_a_q;
    arg_b_d = arg_b_q;
    if (commit & sel(wa, ARG_A_OFF)) arg_a_d = strb_merge(arg_a_q, wd, ws);
    if (commit & sel(wa, ARG_B_OFF)) arg_b_d = strb_merge(arg_b_q, wd, ws);
    result_d = result_vld ? result : result_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_vld_q   <= 1'b0;
      r_vld_q   <= 1'b0;
      r_data_q  <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      arg_a_q   <= '0;
      arg_b_q   <= '0;
      result_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_vld_q   <= b_vld_d;
      r_vld_q   <= r_vld_d;
      r_data_q  <= r_data_d;
      start_q   <= start_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      arg_a_q   <= arg_a_d;
      arg_b_q   <= arg_b_d;
      result_q  <= result_d;
    end
  end

  assign s_axi_control.AWREADY = ~aw_full_q;
  assign s_axi_control.WREADY  = ~w_full_q;
  assign s_axi_control.BVALID  = b_vld_q;
  assign s_axi_control.BRESP   = RESP_OKAY;
  assign s_axi_control.ARREADY = ~r_vld_q;
  assign s_axi_control.RVALID  = r_vld_q;
  assign s_axi_control.RDATA   = r_data_q;
  assign s_axi_control.RRESP   = RESP_OKAY;

  assign ap_start = start_q;
  assign arg_a    = arg_a_q;
  assign arg_b    = arg_b_q;

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Directed bench for axil_ctrl_regs; read data is
// checked against a queue of expected words.
module tb_axil_ctrl_regs;
  import axil_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_ctrl_if #(
    .HOST_AXI_ADDR_BITS(6),
    .HOST_AXI_DATA_BITS(32)
  ) bus ();

  logic        ap_start;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b0;
  logic        ap_ready = 1'b0;
  logic [31:0] arg_a;
  logic [31:0] arg_b;
  logic [31:0] result = '0;
  logic        result_vld = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  axil_ctrl_regs #(
    .HOST_AXI_ADDR_BITS(6),
    .HOST_AXI_DATA_BITS(32)
  ) dut (
    .clock        (clk),
    .reset        (rst),
    .s_axi_control(bus),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .arg_a        (arg_a),
    .arg_b        (arg_b),
    .result       (result),
    .result_vld   (result_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    logic aw_go, w_go;
    int n;
    bus.AWADDR = a;
    bus.WDATA = d;
    bus.WSTRB = s;
    bus.AWVALID = 1'b1;
    bus.WVALID = 1'b1;
    n = 0;
    while ((bus.AWVALID || bus.WVALID) && n < 40) begin
      aw_go = bus.AWVALID && bus.AWREADY;
      w_go = bus.WVALID && bus.WREADY;
      tick();
      n++;
      if (aw_go) bus.AWVALID = 1'b0;
      if (w_go) bus.WVALID = 1'b0;
    end
    chk("aw_w_accept", {30'b0, bus.AWVALID, bus.WVALID}, 32'h0);
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b0;
  endtask

  task automatic write(input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic rdy);
    ap_ready = rdy;
    send(a, d, s);
    ap_ready = 1'b0;
    chk("bvalid_lat", {31'b0, bus.BVALID}, 32'h1);
    chk("bresp", {30'b0, bus.BRESP}, 32'h0);
    tick();
  endtask

  task automatic read(input logic [5:0] a, input logic dn);
    logic [31:0] e;
    int n;
    bus.ARADDR = a;
    bus.ARVALID = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 40) begin
      tick();
      n++;
    end
    ap_done = dn;
    tick();
    bus.ARVALID = 1'b0;
    ap_done = 1'b0;
    chk("rvalid_lat", {31'b0, bus.RVALID}, 32'h1);
    e = 32'hxxxxxxxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk($sformatf("rdata@%h", a), bus.RDATA, e);
    chk("rresp", {30'b0, bus.RRESP}, 32'h0);
    if (bus.RREADY) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.AWVALID = 1'b0;
    bus.AWADDR = '0;
    bus.WVALID = 1'b0;
    bus.WDATA = '0;
    bus.WSTRB = '0;
    bus.BREADY = 1'b1;
    bus.ARVALID = 1'b0;
    bus.ARADDR = '0;
    bus.RREADY = 1'b1;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_awready", {31'b0, bus.AWREADY}, 32'h1);
    chk("rst_wready", {31'b0, bus.WREADY}, 32'h1);
    chk("rst_arready", {31'b0, bus.ARREADY}, 32'h1);
    chk("rst_bvalid", {31'b0, bus.BVALID}, 32'h0);
    chk("rst_rvalid", {31'b0, bus.RVALID}, 32'h0);
    chk("rst_rdata", bus.RDATA, 32'h0);
    chk("rst_start", {31'b0, ap_start}, 32'h0);
    chk("rst_arg_a", arg_a, 32'h0);
    chk("rst_arg_b", arg_b, 32'h0);

    write(6'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    chk("arg_a_full", arg_a, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    read(6'h10, 1'b0);

    write(6'h18, 32'h11223344, 4'hF, 1'b0);
    bus.WDATA = 32'h0000AB00;
    bus.WSTRB = 4'h2;
    bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w_held_wready", {31'b0, bus.WREADY}, 32'h0);
      chk("w_held_arg_b", arg_b, 32'h11223344);
      tick();
    end
    bus.AWADDR = 6'h18;
    bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    chk("late_aw_bvalid", {31'b0, bus.BVALID}, 32'h1);
    chk("arg_b_strobe", arg_b, 32'h1122AB44);
    chk("late_aw_wready", {31'b0, bus.WREADY}, 32'h1);
    tick();

    write(6'h00, 32'h1, 4'hF, 1'b0);
    chk("start_set", {31'b0, ap_start}, 32'h1);
    repeat (4) tick();
    chk("start_hold", {31'b0, ap_start}, 32'h1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    chk("start_clr", {31'b0, ap_start}, 32'h0);
    ap_done = 1'b1;
    result_vld = 1'b1;
    result = 32'h2A;
    tick();
    ap_done = 1'b0;
    result_vld = 1'b0;
    result = 32'hFFFF_FFFF;
    exp_q.push_back(32'hA);
    read(6'h00, 1'b0);
    exp_q.push_back(32'h0);
    read(6'h00, 1'b0);

    write(6'h00, 32'h1, 4'h1, 1'b1);
    chk("start_set_wins", {31'b0, ap_start}, 32'h1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    chk("start_clr2", {31'b0, ap_start}, 32'h0);
    exp_q.push_back(32'h8);
    read(6'h00, 1'b0);
    exp_q.push_back(32'h2A);
    read(6'h20, 1'b0);

    ap_idle = 1'b1;
    exp_q.push_back(32'h4);
    read(6'h00, 1'b1);
    exp_q.push_back(32'h6);
    read(6'h00, 1'b0);

    bus.BREADY = 1'b0;
    send(6'h10, 32'h1, 4'hF);
    chk("bp_first_b", {31'b0, bus.BVALID}, 32'h1);
    chk("bp_arg_a", arg_a, 32'h1);
    bus.AWADDR = 6'h18;
    bus.WDATA = 32'h55;
    bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1;
    bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready_bvalid",
          {29'b0, bus.AWREADY, bus.WREADY, bus.BVALID}, 32'h1);
      chk("bp_arg_b", arg_b, 32'h1122AB44);
      tick();
    end
    bus.BREADY = 1'b1;
    tick();
    chk("bp_b_drain", {31'b0, bus.BVALID}, 32'h0);
    tick();
    chk("bp_second_b", {31'b0, bus.BVALID}, 32'h1);
    chk("bp_arg_b_new", arg_b, 32'h55);
    tick();
    chk("bp_b_done", {31'b0, bus.BVALID}, 32'h0);
    exp_q.push_back(32'h0);
    read(6'h3C, 1'b0);
    write(6'h3C, 32'hFFFFFFFF, 4'hF, 1'b0);
    chk("unmapped_arg_a", arg_a, 32'h1);
    chk("unmapped_arg_b", arg_b, 32'h55);

    write(6'h00, 32'h1, 4'hF, 1'b0);
    bus.RREADY = 1'b0;
    bus.ARADDR = 6'h10;
    bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    tick();
    chk("rr_hold_rvalid", {31'b0, bus.RVALID}, 32'h1);
    chk("rr_hold_rdata", bus.RDATA, 32'h1);
    chk("rr_hold_arready", {31'b0, bus.ARREADY}, 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", {31'b0, bus.RVALID}, 32'h0);
    chk("mid_rst_start", {31'b0, ap_start}, 32'h0);
    chk("mid_rst_rdata", bus.RDATA, 32'h0);
    chk("mid_rst_arg_a", arg_a, 32'h0);
    chk("mid_rst_arg_b", arg_b, 32'h0);
    rst = 1'b0;
    bus.RREADY = 1'b1;
    tick();
    chk("post_rst_arready", {31'b0, bus.ARREADY}, 32'h1);
    exp_q.push_back(32'h0);
    read(6'h20, 1'b0);
    exp_q.push_back(32'h4);
    read(6'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
